// File: rtl/fc_arb_pkg.sv
// Shared types and constants for the FC L2 request arbiter.
package fc_arb_pkg;

    // Largest supported requester count and the index width that covers it.
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    // Default depth of the outstanding-transaction ID FIFO.
    localparam int MAX_OUTST_DEF = 4;

    typedef logic [IDX_W-1:0] req_idx_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Round-robin successor of idx among n requesters.
    function automatic req_idx_t next_idx(input req_idx_t idx, input int n);
        int nxt;
        nxt = int'(idx) + 1;
        return (nxt >= n) ? '0 : req_idx_t'(nxt);
    endfunction

endpackage

// File: rtl/fc_arb_id_fifo.sv
// In-order FIFO of requester indices, one entry per granted transaction
// still waiting for its response.
module fc_arb_id_fifo
    import fc_arb_pkg::*;
#(
    parameter int DEPTH = MAX_OUTST_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [IDX_W-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [IDX_W-1:0] head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [IDX_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointer and occupancy next-state; simultaneous push/pop keeps the count.
    always_comb begin
        wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
        rd_d  = do_pop ? ptr_inc(rd_q) : rd_q;
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Storage and pointer registers; reset discards every entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) begin
                mem_q[wr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/fc_l2_req_arbiter.sv
// Round-robin arbiter funnelling N_REQ TCDM-style requesters onto one L2
// master port, with in-order routing of responses back to their requester.
//
// Handshake: a request is offered while req is high and is accepted in the
// cycle where req and gnt are both high; the requester holds address and
// data stable until that cycle. Responses carry no ID: r_valid is a
// single-cycle strobe, returned in the same order the grants were given.
module fc_l2_req_arbiter
    import fc_arb_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int MAX_OUTST = MAX_OUTST_DEF
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    // requester side
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ*32-1:0] add_i,
    input  logic [N_REQ-1:0]    wen_i,
    input  logic [N_REQ*32-1:0] wdata_i,
    input  logic [N_REQ*4-1:0]  be_i,
    output logic [N_REQ-1:0]    gnt_o,
    output logic [N_REQ-1:0]    r_valid_o,
    output logic [N_REQ*32-1:0] r_rdata_o,
    output logic [N_REQ-1:0]    r_opc_o,
    // L2 master side
    output logic                req_o,
    output logic [31:0]         add_o,
    output logic                wen_o,
    output logic [31:0]         wdata_o,
    output logic [3:0]          be_o,
    input  logic                gnt_i,
    input  logic                r_valid_i,
    input  logic [31:0]         r_rdata_i,
    input  logic                r_opc_i,
    // status / debug
    output logic                unexp_rsp_o,
    output logic                dbg_state_o,
    output logic [IDX_W-1:0]    dbg_rr_ptr_o
);

    arb_state_e       state_q, state_d;
    req_idx_t         lock_idx_q, lock_idx_d;
    req_idx_t         rr_ptr_q, rr_ptr_d;
    logic             unexp_q, unexp_d;

    logic [MAX_REQ-1:0] req_pad;
    req_idx_t         rr_win;
    logic             rr_found;
    logic [IDX_W:0]   cand_sum;
    req_idx_t         cand;
    req_idx_t         win_idx;
    logic             win_valid;
    logic             hs;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    req_idx_t         fifo_head;

    assign req_pad = MAX_REQ'(req_i);

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        rr_win   = '0;
        rr_found = 1'b0;
        cand_sum = '0;
        cand     = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < N_REQ) begin
                cand_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
                if (cand_sum >= (IDX_W+1)'(N_REQ)) begin
                    cand_sum = cand_sum - (IDX_W+1)'(N_REQ);
                end
                cand = cand_sum[IDX_W-1:0];
                if (!rr_found && req_pad[cand]) begin
                    rr_found = 1'b1;
                    rr_win   = cand;
                end
            end
        end
    end

    // A pending ungranted request keeps its slot; otherwise round-robin decides.
    assign win_idx   = (state_q == ARB_LOCKED) ? lock_idx_q : rr_win;
    assign win_valid = (state_q == ARB_LOCKED) ? req_pad[lock_idx_q] : rr_found;

    // The FIFO full flag is purely registered, so r_valid_i never reaches req_o.
    assign req_o = win_valid & ~fifo_full;
    assign hs    = req_o & gnt_i;

    // Payload mux and per-requester grant; idle selects requester 0.
    always_comb begin
        add_o   = add_i[31:0];
        wen_o   = wen_i[0];
        wdata_o = wdata_i[31:0];
        be_o    = be_i[3:0];
        gnt_o   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == req_idx_t'(i)) begin
                add_o    = add_i[i*32 +: 32];
                wen_o    = wen_i[i];
                wdata_o  = wdata_i[i*32 +: 32];
                be_o     = be_i[i*4 +: 4];
                gnt_o[i] = req_o & gnt_i;
            end
        end
    end

    // Response routing: only the head-of-FIFO requester sees r_valid.
    always_comb begin
        r_valid_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            r_valid_o[i] = fifo_pop & (fifo_head == req_idx_t'(i));
        end
    end

    assign r_rdata_o = {N_REQ{r_rdata_i}};
    assign r_opc_o   = {N_REQ{r_opc_i}};
    assign fifo_pop  = r_valid_i & ~fifo_empty;

    fc_arb_id_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (hs),
        .data_i  (win_idx),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    // Arbitration FSM next-state: lock on an ungranted offer, unlock on handshake.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        if (hs) begin
            rr_ptr_d = next_idx(win_idx, N_REQ);
            state_d  = ARB_IDLE;
        end else if (req_o) begin
            state_d    = ARB_LOCKED;
            lock_idx_d = win_idx;
        end else if (state_q == ARB_LOCKED && !fifo_full && !win_valid) begin
            // locked requester withdrew; fall back to normal arbitration
            state_d = ARB_IDLE;
        end
    end

    // Sticky flag for a response that arrives with nothing outstanding.
    assign unexp_d = unexp_q | (r_valid_i & fifo_empty);

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB_IDLE;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
            unexp_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            unexp_q    <= unexp_d;
        end
    end

    assign unexp_rsp_o  = unexp_q;
    assign dbg_state_o  = (state_q == ARB_LOCKED);
    assign dbg_rr_ptr_o = rr_ptr_q;

endmodule
